// File: rtl/branch_pc_sequencer.sv
// ============================================================================
// Module   : branch_pc_sequencer
// Purpose  : PC register with fetch increment, direct load and a multi-cycle
//            conditional-branch sequencer driven by the CON flip-flop result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_pc_sequencer #(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  OFFSET_BITS = 19,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                inc_en,
  input  logic                pc_ld,
  input  logic [PC_WIDTH-1:0] pc_d,
  input  logic                br_start,
  input  logic [31:0]         ir_in,
  input  logic                con_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                con_en,
  output logic                ra_out,
  output logic                busy,
  output logic                done,
  output logic                taken
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RESOLVE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int C_EXT_BITS = PC_WIDTH - OFFSET_BITS;

  logic [2:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, npc_d;
  logic [PC_WIDTH-1:0] off_q, off_d;
  logic                taken_q, taken_d;

  logic [PC_WIDTH-1:0] w_off_ext;
  logic                w_unused_ir;

  assign w_off_ext   = {{C_EXT_BITS{ir_in[OFFSET_BITS-1]}}, ir_in[OFFSET_BITS-1:0]};
  assign w_unused_ir = ^ir_in[31:OFFSET_BITS];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      off_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= npc_d;
      off_q   <= off_d;
      taken_q <= taken_d;
    end
  end

  // Requests are only honoured in IDLE; anything arriving while busy is dropped.
  always_comb begin
    state_d = state_q;
    npc_d   = pc_q;
    off_d   = off_q;
    taken_d = taken_q;
    case (state_q)
      S_IDLE: begin
        if (pc_ld) begin
          npc_d = pc_d;
        end else if (br_start) begin
          off_d   = w_off_ext;
          taken_d = 1'b0;
          state_d = S_CAPTURE;
        end else if (inc_en) begin
          npc_d = pc_q + 1'b1;
        end
      end
      S_CAPTURE: state_d = S_WAIT;
      S_WAIT:    state_d = S_RESOLVE;
      S_RESOLVE: begin
        if (con_in) begin
          npc_d   = pc_q + off_q;
          taken_d = 1'b1;
        end else begin
          taken_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    con_en = 1'b0;
    ra_out = 1'b0;
    done   = 1'b0;
    busy   = (state_q != S_IDLE);
    case (state_q)
      S_CAPTURE: begin
        con_en = 1'b1;
        ra_out = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign pc_out = pc_q;
  assign taken  = taken_q;

endmodule

`default_nettype wire

// File: doc/branch_pc_sequencer.md
Name: branch_pc_sequencer

Overview:
Program-counter register plus the multi-cycle branch sequencer that consumes the CON flip-flop's result. On a conditional-branch instruction it captures the sign-extended offset, asks the datapath to drive Ra onto the bus, and pulses the CON FF enable. It then samples the CON output and either adds the offset to PC or leaves PC unchanged. It also performs the normal fetch increment and the jr/jal-style direct PC load.

Parameters:
PC_WIDTH, 32, width of PC and of all address arithmetic.
OFFSET_BITS, 19, width of the IR immediate field C (ir_in[OFFSET_BITS-1:0]), sign-extended to PC_WIDTH.
RESET_PC, 0, value loaded into PC on reset.

Ports:
clock  in  1  system clock, rising-edge.
clear  in  1  asynchronous, active-low reset.
inc_en  in  1  fetch increment request: PC <= PC+1.
pc_ld  in  1  direct load request: PC <= pc_d.
pc_d  in  PC_WIDTH  load value for pc_ld (from bus).
br_start  in  1  start branch resolution for the instruction on ir_in.
ir_in  in  32  instruction register contents.
con_in  in  1  CON FF output (branch condition true).
pc_out  out  PC_WIDTH  current PC.
con_en  out  1  enable to the CON FF; high for exactly one cycle per branch.
ra_out  out  1  request that the datapath drive Ra onto the bus; high in the same cycle as con_en.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the branch has resolved.
taken  out  1  registered result of the last branch; valid from done until the next br_start.

Behaviour:
- Reset (clear=0, asynchronous): pc_out=RESET_PC, state=IDLE, con_en=0, ra_out=0, busy=0, done=0, taken=0, offset register=0.
- Reset mid-operation aborts the sequence; no PC update occurs. Release resumes in IDLE.
- FSM states: IDLE, CAPTURE, WAIT, RESOLVE, DONE. Outputs are Moore, decoded from registered state.
- IDLE: accepts requests with priority pc_ld > br_start > inc_en; only one action per cycle.
  - pc_ld: PC <= pc_d; stay IDLE.
  - br_start: latch off = sign-extend(ir_in[OFFSET_BITS-1:0]); clear taken; go to CAPTURE.
  - inc_en: PC <= PC+1; stay IDLE.
- CAPTURE: con_en=1, ra_out=1 (the CON FF samples bus and IR this cycle); go to WAIT.
- WAIT: settle cycle for the CON FF output; go to RESOLVE.
- RESOLVE: sample con_in.
  - con_in=1: PC <= PC+off, taken <= 1.
  - con_in=0: PC unchanged, taken <= 0.
  - Go to DONE.
- DONE: done=1 for one cycle; new PC is already visible on pc_out; go to IDLE.
- Latency: br_start sampled at edge N gives con_en during cycle N+1, PC update at edge N+3, done high during cycle N+4. The sequencer is back in IDLE and accepting requests at edge N+5.
- While busy=1, inc_en, pc_ld and br_start are ignored and not queued.
- Arithmetic: modulo 2^PC_WIDTH, no overflow flag. Negative offsets subtract. Wrap-around past all-ones goes to 0 and is legal.
- The offset is the PC-relative displacement from the already-incremented PC. The sequencer never adds an extra +1.
- con_in is ignored in every state except RESOLVE.

Test Plan:
- Reset then release, 3 cycles of inc_en -> pc_out=0,1,2,3; busy=0 throughout; con_en never high.
- pc=3, br_start with ir_in[18:0]=5, con_in=1 at RESOLVE -> con_en/ra_out high exactly one cycle (N+1); pc_out=8 at N+4; done pulse at N+4; taken=1.
- pc=8, offset 19'h7FFFE (-2), con_in=1 -> pc_out=6, taken=1. Repeat with con_in=0 -> pc_out stays 6, taken=0, done still pulses.
- pc_ld with pc_d=32'hFFFFFFFE, then branch offset +3 with con_in=1 -> pc_out=32'h00000001 (wrap).
- Same cycle pc_ld=1, br_start=1, inc_en=1 in IDLE -> PC=pc_d, no branch started. During busy, pulse inc_en and br_start -> no effect; done fires once.
- Assert clear in WAIT with con_in=1 -> pc_out=RESET_PC immediately, busy=0, done never pulses, taken=0.
